pkt_framer: RTL

Upstream stage of the packet decoder. Accepts a byte stream over a valid/ready handshake, finds the sync byte, checks the header and checksum, and captures one packet. It presents the 4-bit `info` opcode field plus payload to the decoder over a second valid/ready handshake. Bad packets are dropped and counted, so the decoder only ever sees packets that passed integrity checks.

---
 rtl/pkt_pkg.sv | 22 ++
 rtl/pkt_framer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pkt_pkg.sv
// Types and constants shared by the packet framer and the downstream decoder.
package pkt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    LOAD    = 4'd0,
    STORE   = 4'd1,
    JUMP    = 4'd2,
    ALU_OP  = 4'd3,
    INVALID = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
    S_CHK  = 3'd3,
    S_HOLD = 3'd4
  } framer_state_e;

endpackage

// File: rtl/pkt_framer.sv
// Byte-stream packet framer: finds sync, checks header and XOR checksum,
// holds one good packet for the decoder and counts dropped packets.
//
// state  | meaning
// S_SYNC | hunting for the sync byte, other bytes discarded
// S_HDR  | expecting header {~info, info}
// S_PAY  | shifting in payload bytes, accumulating checksum
// S_CHK  | comparing received checksum with accumulated value
// S_HOLD | packet presented to decoder, input stalled
module pkt_framer
  import pkt_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic [3:0]                 pkt_info,
  output logic [8*PAYLOAD_BYTES-1:0] pkt_payload,
  output logic                       pkt_err,
  output logic [7:0]                 err_count
);

  localparam int PW    = 8 * PAYLOAD_BYTES;
  localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  framer_state_e    state, state_nxt;
  logic [3:0]       info_nxt;
  logic [PW-1:0]    payload_nxt;
  logic [7:0]       chk, chk_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             err_nxt;
  logic [7:0]       count_nxt;
  logic             accept;
  logic             drop;

  // Handshake outputs depend only on the state register.
  assign in_ready  = (state != S_HOLD);
  assign pkt_valid = (state == S_HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt   = state;
    info_nxt    = pkt_info;
    payload_nxt = pkt_payload;
    chk_nxt     = chk;
    idx_nxt     = idx;
    drop        = 1'b0;
    err_nxt     = 1'b0;
    count_nxt   = err_count;

    case (state)
      S_SYNC: begin
        if (accept && in_data == SYNC_BYTE) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (accept) begin
          if (in_data[7:4] == ~in_data[3:0]) begin
            info_nxt  = in_data[3:0];
            chk_nxt   = in_data;
            idx_nxt   = '0;
            state_nxt = S_PAY;
          end else begin
            drop      = 1'b1;
            state_nxt = S_SYNC;
          end
        end
      end
      S_PAY: begin
        if (accept) begin
          payload_nxt = (pkt_payload << 8) | PW'(in_data);
          chk_nxt     = chk ^ in_data;
          idx_nxt     = idx + IDX_W'(1);
          if (idx == LAST_IDX) state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (in_data == chk) begin
            state_nxt = S_HOLD;
          end else begin
            drop      = 1'b1;
            state_nxt = S_SYNC;
          end
        end
      end
      S_HOLD: begin
        if (pkt_ready) state_nxt = S_SYNC;
      end
      default: state_nxt = S_SYNC;
    endcase

    if (drop) begin
      err_nxt = 1'b1;
      if (err_count != 8'hFF) count_nxt = err_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_SYNC;
      pkt_info    <= '0;
      pkt_payload <= '0;
      chk         <= '0;
      idx         <= '0;
      pkt_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      pkt_info    <= info_nxt;
      pkt_payload <= payload_nxt;
      chk         <= chk_nxt;
      idx         <= idx_nxt;
      pkt_err     <= err_nxt;
      err_count   <= count_nxt;
    end
  end

endmodule
